field_extract_stream: RTL and testbench

//  Downstream consumer of a packed wide vector. Accepts one WIDTH-bit word per load handshake.

---
 rtl/field_extract_stream_if.sv | 26 ++
 rtl/field_extract_stream.sv | 57 +++++
 tb/tb_field_extract_stream.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/field_extract_stream_if.sv
// field_extract_stream_if: load handshake and field stream of field_extract_stream
interface field_extract_stream_if #(
   parameter int WIDTH = 128,
   parameter int FIELD = 3,
   parameter int IDXW  = $clog2(WIDTH)
);
   logic             load_valid;
   logic             load_ready;
   logic [WIDTH-1:0] load_data;
   logic [IDXW:0]    load_limit;
   logic             out_valid;
   logic             out_ready;
   logic [FIELD-1:0] out_field;
   logic [IDXW-1:0]  out_index;
   logic             out_last;
   logic [7:0]       crc;
   logic             busy;
   modport master (
      output load_valid, load_data, load_limit, out_ready,
      input  load_ready, out_valid, out_field, out_index, out_last, crc, busy
   );
   modport slave (
      input  load_valid, load_data, load_limit, out_ready,
      output load_ready, out_valid, out_field, out_index, out_last, crc, busy
   );
endinterface

// File: rtl/field_extract_stream.sv
// field_extract_stream: walks a loaded vector in STRIDE steps, streaming FIELD-bit slices and folding them into a CRC-8
module field_extract_stream #(
   parameter int WIDTH  = 128,
   parameter int FIELD  = 3,
   parameter int STRIDE = 2,
   parameter int IDXW   = $clog2(WIDTH)
) (
   input logic                   clk,
   input logic                   reset_l,
   field_extract_stream_if.slave s
);
   typedef enum logic {IDLE, EMIT} state_t;
   state_t                 state, state_nx;
   logic [WIDTH-1:0]       data;
   logic [WIDTH+FIELD-1:0] padded;
   logic [IDXW:0]          limit, limit_c, idx_nx;
   logic [IDXW-1:0]        index;
   logic [7:0]             crc, crc_nx;
   logic                   load, beat, last;
   // zero padding above the MSB makes the tail field read 0 past WIDTH-1
   assign padded  = {{FIELD{1'b0}}, data};
   assign limit_c = (s.load_limit > (IDXW+1)'(WIDTH)) ? (IDXW+1)'(WIDTH) : s.load_limit;
   assign idx_nx  = {1'b0, index} + (IDXW+1)'(STRIDE);
   assign last    = idx_nx >= limit;
   assign load    = s.load_valid && s.load_ready;
   assign beat    = s.out_valid && s.out_ready;
   assign crc_nx  = {crc[6:0], ~^{crc[7], crc[5], crc[4], crc[3]}} ^ 8'(s.out_field);
   assign s.load_ready = (state == IDLE) && reset_l;
   assign s.out_valid  = state == EMIT;
   assign s.busy       = state == EMIT;
   assign s.out_last   = (state == EMIT) && last;
   assign s.out_field  = (state == EMIT) ? padded[index +: FIELD] : '0;
   assign s.out_index  = index;
   assign s.crc        = crc;
   always_comb begin
      state_nx = state;
      state_nx = (load && limit_c != '0) ? EMIT : (beat && last) ? IDLE : state;
   end
   always_ff @(posedge clk) begin
      if (!reset_l) state <= IDLE;
      else          state <= state_nx;
   end
   always_ff @(posedge clk) begin
      if (!reset_l) begin
         index <= '0;
         crc   <= 8'hED;
      end else if (load) begin
         data  <= s.load_data;
         limit <= limit_c;
         index <= '0;
         crc   <= 8'hED;
      end else if (beat) begin
         index <= idx_nx[IDXW-1:0];
         crc   <= crc_nx;
      end
   end
endmodule

// File: tb/tb_field_extract_stream.sv
// tb_field_extract_stream: vector table plus hand sequences; scoreboard queue of expected beats
module tb_field_extract_stream;
   localparam int WIDTH = 128, FIELD = 3, STRIDE = 2, IDXW = 7;
   typedef struct {
      logic [WIDTH-1:0] data;
      logic [IDXW:0]    limit;
      int               beats;
      logic [7:0]       crc;
      bit               known;
      bit               rnd;
   } vec_t;
   typedef struct {
      logic [IDXW-1:0]  idx;
      logic [FIELD-1:0] field;
      logic             last;
   } beat_t;
   logic clk = 0, reset_l = 0;
   logic rand_ready = 0, ready_force = 1;
   int passed = 0, total = 0, beats = 0;
   logic [7:0] mcrc;
   beat_t q[$];
   vec_t vt[7];
   field_extract_stream_if #(.WIDTH(WIDTH), .FIELD(FIELD), .IDXW(IDXW)) f();
   field_extract_stream #(.WIDTH(WIDTH), .FIELD(FIELD), .STRIDE(STRIDE), .IDXW(IDXW)) dut (
      .clk(clk), .reset_l(reset_l), .s(f)
   );
   always #5 clk = ~clk;
   task automatic check(string name, logic [127:0] act, logic [127:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask
   always @(posedge clk) begin
      #2;
      f.out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_force;
   end
   always @(negedge clk) begin
      if (reset_l && f.out_valid && f.out_ready) begin
         beats++;
         if (q.size() == 0) begin
            total++;
            $display("FAIL extra_beat: got index %0d expected none", f.out_index);
         end else begin
            beat_t e;
            e = q.pop_front();
            check("beat_index", f.out_index, e.idx);
            check("beat_field", f.out_field, e.field);
            check("beat_last", f.out_last, e.last);
         end
      end
   end
   task automatic do_load(logic [WIDTH-1:0] d, logic [IDXW:0] lim);
      int n = 0;
      int l;
      logic [7:0] c = 8'hED;
      while (!f.load_ready && n < 100) begin
         @(posedge clk); #1; n++;
      end
      check("load_ready_wait", f.load_ready, 1);
      f.load_valid = 1; f.load_data = d; f.load_limit = lim;
      @(posedge clk); #1;
      f.load_valid = 0;
      l = (lim > WIDTH) ? WIDTH : int'(lim);
      for (int i = 0; i < l; i += STRIDE) begin
         beat_t e;
         for (int b = 0; b < FIELD; b++) e.field[b] = (i + b < WIDTH) ? d[i+b] : 1'b0;
         e.idx = IDXW'(i);
         e.last = (i + STRIDE >= l);
         q.push_back(e);
         c = {c[6:0], ~^{c[7], c[5], c[4], c[3]}} ^ 8'(e.field);
      end
      mcrc = c;
   endtask
   task automatic drain(string name);
      int n = 0;
      while ((q.size() != 0 || f.busy) && n < 3000) begin
         @(posedge clk); #1; n++;
      end
      check({name, "_drain"}, q.size(), 0);
   endtask
   task automatic run(vec_t v, string name);
      beats = 0;
      do_load(v.data, v.limit);
      drain(name);
      check({name, "_beats"}, beats, v.beats);
      check({name, "_crc_model"}, f.crc, mcrc);
      if (v.known) check({name, "_crc"}, f.crc, v.crc);
      check({name, "_idle"}, f.load_ready, 1);
   endtask
   initial begin
      logic [7:0] hold;
      int stalls, n;
      f.load_valid = 0; f.load_data = '0; f.load_limit = '0; f.out_ready = 1;
      vt[0] = '{128'hF, 8'd8, 4, 8'hE7, 1, 0};
      vt[1] = '{{WIDTH{1'b1}}, 8'd200, 64, 8'h00, 0, 0};
      vt[2] = '{128'h0, 8'd1, 1, 8'hDA, 1, 0};
      vt[3] = '{128'h7, 8'd1, 1, 8'hDD, 1, 0};
      vt[4] = '{128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 8'd37, 19, 8'h00, 0, 1};
      vt[5] = '{128'hDEAD_BEEF_0000_FFFF_A5A5_5A5A_1357_9BDF, 8'd127, 64, 8'h00, 0, 1};
      vt[6] = '{128'h5, 8'd0, 0, 8'hED, 1, 0};
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", f.out_valid, 0);
      check("rst_index", f.out_index, 0);
      check("rst_field", f.out_field, 0);
      check("rst_last", f.out_last, 0);
      check("rst_crc", f.crc, 8'hED);
      check("rst_busy", f.busy, 0);
      check("rst_load_ready", f.load_ready, 0);
      reset_l = 1;
      @(posedge clk); #1;
      foreach (vt[i]) begin
         rand_ready = vt[i].rnd;
         run(vt[i], $sformatf("vec%0d", i));
      end
      rand_ready = 0; ready_force = 1;
      // backpressure on the index-2 beat of the first vector
      beats = 0; stalls = 0; n = 0;
      do_load(128'hF, 8'd8);
      while ((q.size() != 0 || f.busy) && n < 200) begin
         if (f.out_valid && f.out_index == 2 && stalls < 5) begin
            ready_force = 0;
            if (stalls == 0) hold = f.crc;
            check("stall_field", f.out_field, 3);
            check("stall_index", f.out_index, 2);
            check("stall_crc", f.crc, hold);
            stalls++;
         end else ready_force = 1;
         @(posedge clk); #1; n++;
      end
      check("stall_count", stalls, 5);
      check("stall_beats", beats, 4);
      check("stall_crc_final", f.crc, 8'hE7);
      ready_force = 1;
      do_load(128'h3F, 8'd0);
      repeat (5) begin
         check("lim0_valid", f.out_valid, 0);
         check("lim0_load_ready", f.load_ready, 1);
         @(posedge clk); #1;
      end
      check("lim0_crc", f.crc, 8'hED);
      do_load({WIDTH{1'b1}}, 8'd200);
      n = 0;
      while (!(f.out_valid && f.out_index == 4) && n < 100) begin
         @(posedge clk); #1; n++;
      end
      check("abort_reach", f.out_index, 4);
      reset_l = 0;
      @(posedge clk); #1;
      check("abort_valid", f.out_valid, 0);
      check("abort_crc", f.crc, 8'hED);
      check("abort_load_ready", f.load_ready, 0);
      reset_l = 1;
      q.delete();
      #1;
      check("abort_release_ready", f.load_ready, 1);
      @(posedge clk); #1;
      check("abort_no_beats", f.out_valid, 0);
      run(vt[0], "after_abort");
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
